// File: rtl/key_expansion_seq_if.sv
// key_expansion_seq_if
//   Bundle between the AES key-schedule block and its user (the cipher
//   datapath or a bench).
//   start       user -> block  request expansion of key
//   key         user -> block  Nk*32-bit cipher key, w[0] in the MSBs
//   busy        block -> user  expansion in progress
//   valid       block -> user  round_keys complete and stable
//   round_keys  block -> user  round key r at [128*r +: 128], w[4r] in its MSBs
//   dbg_state   block -> user  current FSM state (debug observation only)
// Handshake: start is accepted only on an edge where busy is low.  On that
// edge valid drops and busy rises.  busy stays high for W-Nk cycles.  On the
// edge that writes the last word, busy falls and valid rises.  valid and
// round_keys then hold until the next accepted start.  A start seen while
// busy is high is dropped without effect.
interface key_expansion_seq_if #(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
);
    logic                     start;
    logic [Nk*32-1:0]         key;
    logic                     busy;
    logic                     valid;
    logic [128*(Nr+1)-1:0]    round_keys;
    logic [1:0]               dbg_state;

    modport master (output start, key, input busy, valid, round_keys, dbg_state);
    modport slave  (input start, key, output busy, valid, round_keys, dbg_state);
endinterface

// File: rtl/key_expansion_seq.sv
// aes_sub_bytes
//   AES SubBytes on a 128-bit state: each byte goes through the S-box.
//   din   in   128   state in
//   dout  out  128   substituted state
// The S-box is computed algebraically: the GF(2^8) inverse is x^254, formed
// by a square-and-multiply chain, followed by the FIPS-197 affine transform.
module aes_sub_bytes (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x2, x3, x12, x15, x240, x252, inv;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);                 // x^30
        x240 = gf_mul(x240, x240);               // x^60
        x240 = gf_mul(x240, x240);               // x^120
        x240 = gf_mul(x240, x240);               // x^240
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);                 // x^254 (0 maps to 0)
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        dout = '0;
        for (int b = 0; b < 16; b++) dout[8*b +: 8] = sbox(din[8*b +: 8]);
    end
endmodule

// key_expansion_seq
//   Iterative AES key schedule (FIPS-197 KeyExpansion), one 32-bit word per
//   clock, feeding the flat round-key bus of the cipher.
//   clk    in   1    rising-edge clock
//   reset  in   1    asynchronous, active-high
//   bus    slave modport of key_expansion_seq_if (start, key, busy, valid,
//                    round_keys, dbg_state)
// The round_keys register is the word array w[] itself; w[j] lives at
// round_keys[128*(j/4) + 32*(3 - j%4) +: 32].
module key_expansion_seq #(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic                 clk,
    input  logic                 reset,
    key_expansion_seq_if.slave   bus
);
    localparam int W   = 4 * (Nr + 1);
    localparam int RKW = 128 * (Nr + 1);
    localparam int IW  = $clog2(W + 1);
    localparam int BW  = $clog2(RKW);

    if (Nk != 4 && Nk != 6 && Nk != 8) begin : g_bad_nk
        $error("key_expansion_seq: Nk must be 4, 6 or 8");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    i_q, i_d;
    logic [2:0]       cnt_q, cnt_d;          // i mod Nk, kept without a divider
    logic [7:0]       rcon_q, rcon_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [RKW-1:0]   rk_q;
    logic             load, wr;

    int               prev_idx, back_idx;
    logic [31:0]      prev_word, back_word, sub_in, sb_word, temp, new_word;
    logic [127:0]     sb_out;
    logic [95:0]      sb_unused;

    function automatic logic [BW-1:0] word_lsb(input int j);
        return BW'((j / 4) * 128 + (3 - (j % 4)) * 32);
    endfunction

    // Operand fetch: w[i-1] and w[i-Nk].  Indices are clamped so the select
    // stays in range in IDLE, where i is 0.
    always_comb begin
        prev_idx = int'(i_q) - 1;
        back_idx = int'(i_q) - Nk;
        if (prev_idx < 0) prev_idx = 0;
        if (back_idx < 0) back_idx = 0;
        prev_word = rk_q[word_lsb(prev_idx) +: 32];
        back_word = rk_q[word_lsb(back_idx) +: 32];
        // RotWord only on the rcon step; the Nk=8 mid-step substitutes unrotated.
        sub_in = (cnt_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    end

    // Single shared SubBytes: the word rides in the top lane, other lanes idle.
    aes_sub_bytes u_sub_bytes (
        .din  ({sub_in, 96'h0}),
        .dout (sb_out)
    );
    assign {sb_word, sb_unused} = sb_out;

    always_comb begin
        temp = prev_word;
        if (cnt_q == 3'd0)
            temp = sb_word ^ {rcon_q, 24'h0};
        else if (Nk == 8 && cnt_q == 3'd4)
            temp = sb_word;
        new_word = back_word ^ temp;
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        cnt_d   = cnt_q;
        rcon_d  = rcon_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        load    = 1'b0;
        wr      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    i_d     = IW'(Nk);
                    cnt_d   = 3'd0;
                    rcon_d  = 8'h01;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                wr    = 1'b1;
                i_d   = i_q + IW'(1);
                cnt_d = (cnt_q == 3'(Nk - 1)) ? 3'd0 : cnt_q + 3'd1;
                if (cnt_q == 3'd0)
                    rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                if (i_q == IW'(W - 1)) begin
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            cnt_q   <= '0;
            rcon_q  <= 8'h01;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            cnt_q   <= cnt_d;
            rcon_q  <= rcon_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rk_q <= '0;
        end else if (load) begin
            for (int j = 0; j < Nk; j++)
                rk_q[word_lsb(j) +: 32] <= bus.key[32*(Nk-j)-1 -: 32];
        end else if (wr) begin
            rk_q[word_lsb(int'(i_q)) +: 32] <= new_word;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.valid      = valid_q;
    assign bus.round_keys = rk_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_key_expansion_seq.sv
// tb_key_expansion_seq
//   Drives one key_expansion_seq per key size (Nk = 4, 6, 8) from a shared
//   clock/reset and checks latency, handshake and every round key against a
//   table-driven FIPS-197 key schedule plus published answer words.
module tb_key_expansion_seq;
    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    logic [127:0] exp_q[$];

    key_expansion_seq_if #(.Nk(4)) bus4 ();
    key_expansion_seq_if #(.Nk(6)) bus6 ();
    key_expansion_seq_if #(.Nk(8)) bus8 ();

    key_expansion_seq #(.Nk(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
    key_expansion_seq #(.Nk(6)) dut6 (.clk(clk), .reset(reset), .bus(bus6));
    key_expansion_seq #(.Nk(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

    // ---------------- clock / reset ----------------
    initial begin
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sb_ref(input logic [7:0] x);
        logic [10:0] base;
        base = 11'(2047 - 8 * int'(x));
        return SBOX_TAB[base -: 8];
    endfunction

    function automatic logic [31:0] sub_word_ref(input logic [31:0] x);
        return {sb_ref(x[31:24]), sb_ref(x[23:16]), sb_ref(x[15:8]), sb_ref(x[7:0])};
    endfunction

    // Textbook KeyExpansion; pushes the Nr+1 expected round keys onto exp_q.
    task automatic model_push(input int nk, input logic [255:0] k);
        logic [7:0]  rcon_tab [10];
        logic [31:0] w [60];
        logic [31:0] t;
        int nw;
        rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        nw = 4 * (nk + 7);
        for (int j = 0; j < nk; j++) w[j] = k[32*(nk-1-j) +: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0)
                t = sub_word_ref({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk - 1], 24'h0};
            else if (nk > 6 && i % nk == 4)
                t = sub_word_ref(t);
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < nk + 7; r++)
            exp_q.push_back({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
    endtask

    // ---------------- driver / access ----------------
    task automatic drive(input int nk, input logic st, input logic [255:0] k);
        bus4.start = (nk == 4) ? st : 1'b0;
        bus6.start = (nk == 6) ? st : 1'b0;
        bus8.start = (nk == 8) ? st : 1'b0;
        bus4.key   = k[127:0];
        bus6.key   = k[191:0];
        bus8.key   = k;
    endtask

    function automatic logic get_busy(input int nk);
        return (nk == 4) ? bus4.busy : (nk == 6) ? bus6.busy : bus8.busy;
    endfunction

    function automatic logic get_valid(input int nk);
        return (nk == 4) ? bus4.valid : (nk == 6) ? bus6.valid : bus8.valid;
    endfunction

    function automatic logic [1919:0] get_rk(input int nk);
        if (nk == 4) return 1920'(bus4.round_keys);
        if (nk == 6) return 1920'(bus6.round_keys);
        return bus8.round_keys;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
        end
    endtask

    // One full expansion.  pulse_a/pulse_b: edge counts after acceptance at
    // which an extra start (with alt_k) is raised for one cycle; -1 = none.
    task automatic run_expansion(input int nk, input logic [255:0] k, input string tag,
                                 input int pulse_a, input int pulse_b, input logic [255:0] alt_k);
        int lat;
        int n;
        int busy_cycles;
        logic [1919:0] rk;
        lat = 4 * (nk + 7) - nk;
        model_push(nk, k);
        drive(nk, 1'b1, k);
        @(posedge clk); #1;
        drive(nk, 1'b0, k);
        check({tag, " busy_after_accept"}, 128'(get_busy(nk)), 128'd1);
        check({tag, " valid_after_accept"}, 128'(get_valid(nk)), 128'd0);
        busy_cycles = 1;
        n = 0;
        do begin
            if (n == pulse_a || n == pulse_b) drive(nk, 1'b1, alt_k);
            else drive(nk, 1'b0, k);
            @(posedge clk); #1;
            n++;
            if (get_busy(nk)) busy_cycles++;
        end while (!get_valid(nk) && n < lat + 20);
        drive(nk, 1'b0, k);
        check({tag, " latency"}, 128'(n), 128'(lat));
        check({tag, " busy_cycles"}, 128'(busy_cycles), 128'(lat));
        repeat (3) @(posedge clk);
        #1;
        check({tag, " valid_held"}, 128'(get_valid(nk)), 128'd1);
        check({tag, " busy_low"}, 128'(get_busy(nk)), 128'd0);
        rk = get_rk(nk);
        for (int r = 0; r < nk + 7; r++)
            check($sformatf("%s rk%0d", tag, r), rk[128*r +: 128], exp_q.pop_front());
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [255:0] k1, k2, k3, kr, alt;
        logic [1919:0] rk;
        logic ever_valid;
        k1 = 256'(128'h2b7e151628aed2a6abf7158809cf4f3c);
        k2 = 256'(192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b);
        k3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

        // Reset with the clock stopped.
        reset = 1'b1;
        drive(4, 1'b0, '0);
        #2;
        check("rst busy4", 128'(bus4.busy), 128'd0);
        check("rst valid4", 128'(bus4.valid), 128'd0);
        check("rst valid8", 128'(bus8.valid), 128'd0);
        check("rst state4", 128'(bus4.dbg_state), 128'd0);
        rk = get_rk(8);
        for (int r = 0; r < 15; r++) check($sformatf("rst rk8_%0d", r), rk[128*r +: 128], 128'd0);
        #2;
        reset = 1'b0;
        clk_en = 1'b1;

        // Idle with start low: nothing happens.
        ever_valid = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus4.valid || bus6.valid || bus8.valid) ever_valid = 1'b1;
        end
        check("idle no_valid", 128'(ever_valid), 128'd0);
        check("idle rk4_10", get_rk(4)[1280 +: 128], 128'd0);

        // Known-answer vectors for each key size.
        run_expansion(4, k1, "kat128", -1, -1, '0);
        rk = get_rk(4);
        check("kat128 w4", 128'(rk[224 +: 32]), 128'(32'ha0fafe17));
        check("kat128 rk10", rk[1280 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run_expansion(6, k2, "kat192", -1, -1, '0);
        rk = get_rk(6);
        check("kat192 w6", 128'(rk[160 +: 32]), 128'(32'hfe0c91f7));
        check("kat192 w51", 128'(rk[1536 +: 32]), 128'(32'h01002202));

        run_expansion(8, k3, "kat256", -1, -1, '0);
        rk = get_rk(8);
        check("kat256 w8", 128'(rk[352 +: 32]), 128'(32'h9ba35411));
        check("kat256 w12", 128'(rk[480 +: 32]), 128'(32'ha8b09c1a));
        check("kat256 w59", 128'(rk[1792 +: 32]), 128'(32'h706c631e));

        // Start while busy is ignored; then restart from DONE with a zero key.
        alt = {$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()};
        run_expansion(4, k1, "busy_start", 5, 20, alt);
        run_expansion(4, '0, "zero_key", -1, -1, '0);
        check("zero_key rk10", get_rk(4)[1280 +: 128], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Reset in the middle of an expansion.
        drive(4, 1'b1, k1);
        @(posedge clk); #1;
        drive(4, 1'b0, k1);
        repeat (17) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst busy", 128'(bus4.busy), 128'd0);
        check("midrst valid", 128'(bus4.valid), 128'd0);
        rk = get_rk(4);
        for (int r = 0; r < 11; r++) check($sformatf("midrst rk%0d", r), rk[128*r +: 128], 128'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_expansion(4, k1, "after_rst", -1, -1, '0);

        // Random keys; some runs raise start on the edge where valid rises.
        for (int nk = 4; nk <= 8; nk += 2) begin
            for (int t = 0; t < 2; t++) begin
                kr = {$urandom(), $urandom(), $urandom(), $urandom(),
                      $urandom(), $urandom(), $urandom(), $urandom()};
                alt = {$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom(), $urandom()};
                run_expansion(nk, kr, $sformatf("rand_nk%0d_%0d", nk, t),
                              (t == 0) ? -1 : $urandom_range(1, 30),
                              (t == 0) ? -1 : 4 * (nk + 7) - nk - 1, alt);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
